// File: rtl/wavetable_offset_arbiter_if.sv
// Voice/ROM bus of the wavetable offset arbiter.
// The master side is the environment: voice controllers plus the offset ROM.
// The slave side is the arbiter itself.
interface wavetable_offset_arbiter_if #(
   parameter int unsigned VOICES = 8,
   parameter int unsigned VW     = 3
);
   logic [VOICES-1:0]   req;
   logic [VOICES*5-1:0] instr;
   logic                rom_re;
   logic [4:0]          rom_addr;
   logic [7:0]          rom_data;
   logic [VOICES-1:0]   ack;
   logic [7:0]          offset;
   logic [VW-1:0]       offset_voice;
   logic                offset_valid;
   logic                err;

   modport master (
      output req, instr, rom_data,
      input  rom_re, rom_addr, ack, offset, offset_voice, offset_valid, err
   );

   modport slave (
      input  req, instr, rom_data,
      output rom_re, rom_addr, ack, offset, offset_voice, offset_valid, err
   );
endinterface

// File: rtl/wavetable_offset_arbiter.sv
// Round-robin arbiter that shares the wavetable offset ROM between voices.
// It performs one lookup every three cycles: IDLE (arbitrate and latch),
// ISSUE (ROM read), CAPTURE (register the answer). The result strobes
// are visible during the following IDLE cycle.
module wavetable_offset_arbiter #(
   parameter int unsigned VOICES   = 8,
   parameter int unsigned VW       = 3,
   parameter int unsigned ROM_SIZE = 29
) (
   input  logic                        clk,
   input  logic                        rst,
   wavetable_offset_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

   state_t            state_q, state_d;
   logic [VW-1:0]     winner_q, winner_d;
   logic [VW-1:0]     last_q, last_d;
   logic              err_flag_q, err_flag_d;
   logic              rom_re_q, rom_re_d;
   logic [4:0]        rom_addr_q, rom_addr_d;
   logic [VOICES-1:0] ack_q, ack_d;
   logic [7:0]        offset_q, offset_d;
   logic [VW-1:0]     offset_voice_q, offset_voice_d;
   logic              offset_valid_q, offset_valid_d;
   logic              err_q, err_d;

   logic [4:0]        instr_arr [VOICES];
   logic              found;
   logic [VW-1:0]     pick;
   logic [VW-1:0]     cand;
   logic [4:0]        pick_instr;
   logic              in_range;

   for (genvar g = 0; g < VOICES; g++) begin : g_unpack
      assign instr_arr[g] = bus.instr[5*g+4:5*g];
   end

   // Round-robin search starting just after the last served voice.
   always_comb begin
      found      = 1'b0;
      pick       = '0;
      cand       = '0;
      pick_instr = '0;
      for (int unsigned i = 1; i <= VOICES; i++) begin
         cand = VW'((32'(last_q) + i) % VOICES);
         if (!found && bus.req[cand]) begin
            found      = 1'b1;
            pick       = cand;
            pick_instr = instr_arr[cand];
         end
      end
      in_range = (32'(pick_instr) < ROM_SIZE);
   end

   // Next-state and next-output logic of the lookup sequencer.
   // The range check is made while latching in IDLE so that rom_re/rom_addr
   // are already registered and driven during the ISSUE cycle.
   always_comb begin
      state_d        = state_q;
      winner_d       = winner_q;
      last_d         = last_q;
      err_flag_d     = err_flag_q;
      rom_re_d       = 1'b0;
      rom_addr_d     = rom_addr_q;
      ack_d          = '0;
      offset_d       = offset_q;
      offset_voice_d = offset_voice_q;
      offset_valid_d = 1'b0;
      err_d          = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               winner_d = pick;
               if (in_range) begin
                  rom_re_d   = 1'b1;
                  rom_addr_d = pick_instr;
                  err_flag_d = 1'b0;
               end else begin
                  err_flag_d = 1'b1;
               end
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            state_d = CAPTURE;
         end
         CAPTURE: begin
            offset_d         = err_flag_q ? 8'h00 : bus.rom_data;
            offset_voice_d   = winner_q;
            ack_d[winner_q]  = 1'b1;
            offset_valid_d   = 1'b1;
            err_d            = err_flag_q;
            last_d           = winner_q;
            state_d          = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         winner_q       <= '0;
         last_q         <= VW'(VOICES - 1);
         err_flag_q     <= 1'b0;
         rom_re_q       <= 1'b0;
         rom_addr_q     <= '0;
         ack_q          <= '0;
         offset_q       <= '0;
         offset_voice_q <= '0;
         offset_valid_q <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         winner_q       <= winner_d;
         last_q         <= last_d;
         err_flag_q     <= err_flag_d;
         rom_re_q       <= rom_re_d;
         rom_addr_q     <= rom_addr_d;
         ack_q          <= ack_d;
         offset_q       <= offset_d;
         offset_voice_q <= offset_voice_d;
         offset_valid_q <= offset_valid_d;
         err_q          <= err_d;
      end
   end

   assign bus.rom_re       = rom_re_q;
   assign bus.rom_addr     = rom_addr_q;
   assign bus.ack          = ack_q;
   assign bus.offset       = offset_q;
   assign bus.offset_voice = offset_voice_q;
   assign bus.offset_valid = offset_valid_q;
   assign bus.err          = err_q;

endmodule

// File: tb/tb_wavetable_offset_arbiter.sv
// Scoreboard bench for wavetable_offset_arbiter with a behavioural ROM.
module tb_wavetable_offset_arbiter;
   localparam int unsigned VOICES   = 8;
   localparam int unsigned VW       = 3;
   localparam int unsigned ROM_SIZE = 29;

   logic clk = 1'b0;
   logic rst = 1'b1;

   wavetable_offset_arbiter_if #(.VOICES(VOICES), .VW(VW)) bus ();

   wavetable_offset_arbiter #(.VOICES(VOICES), .VW(VW), .ROM_SIZE(ROM_SIZE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Offset ROM: one-cycle registered read gated by rom_re.
   logic [7:0] rom [32];
   always @(posedge clk) begin
      if (bus.rom_re) bus.rom_data <= rom[bus.rom_addr];
   end

   typedef struct {
      int         voice;
      logic [7:0] off;
      logic       err;
      int         cyc;
   } exp_t;

   exp_t       sb [$];
   logic [4:0] addrq [$];
   int         cyc    = 0;
   int         checks = 0;
   int         errors = 0;
   logic       quiet  = 1'b1;
   logic       done   = 1'b0;

   // Monitor: samples on the falling edge and owns every comparison.
   initial begin : monitor
      exp_t              e;
      logic [4:0]        a;
      logic [VOICES-1:0] exp_ack;
      forever begin
         @(negedge clk);
         cyc++;
         if (quiet) begin
            checks++;
            if (bus.rom_re !== 1'b0 || bus.rom_addr !== 5'd0 || bus.ack !== '0 ||
                bus.offset !== 8'h00 || bus.offset_voice !== '0 ||
                bus.offset_valid !== 1'b0 || bus.err !== 1'b0) begin
               errors++;
               $display("FAIL quiet cyc=%0d got re=%b addr=%0d ack=%b off=%h voice=%0d valid=%b err=%b required all zero",
                        cyc, bus.rom_re, bus.rom_addr, bus.ack, bus.offset, bus.offset_voice,
                        bus.offset_valid, bus.err);
            end
         end
         if (bus.rom_re === 1'b1) begin
            checks++;
            if (addrq.size() == 0) begin
               errors++;
               $display("FAIL rom_re cyc=%0d got unexpected read addr=%0d required no read", cyc, bus.rom_addr);
            end else begin
               a = addrq.pop_front();
               if (bus.rom_addr !== a) begin
                  errors++;
                  $display("FAIL rom_addr cyc=%0d got %0d required %0d", cyc, bus.rom_addr, a);
               end
            end
         end
         if (bus.offset_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL result cyc=%0d got unexpected voice=%0d required no result", cyc, bus.offset_voice);
            end else begin
               e = sb.pop_front();
               exp_ack = VOICES'(1) << e.voice;
               if (bus.ack !== exp_ack || bus.offset !== e.off || bus.offset_voice !== VW'(e.voice) ||
                   bus.err !== e.err || cyc != e.cyc) begin
                  errors++;
                  $display("FAIL result cyc=%0d got ack=%b off=%h voice=%0d err=%b required ack=%b off=%h voice=%0d err=%b cyc=%0d",
                           cyc, bus.ack, bus.offset, bus.offset_voice, bus.err,
                           exp_ack, e.off, e.voice, e.err, e.cyc);
               end
            end
         end else if (bus.ack !== '0) begin
            checks++;
            errors++;
            $display("FAIL ack_strobe cyc=%0d got ack=%b required 0 without offset_valid", cyc, bus.ack);
         end
         if (done || cyc > 3000) begin
            checks++;
            if (cyc > 3000 || sb.size() != 0 || addrq.size() != 0) begin
               errors++;
               $display("FAIL drain cyc=%0d got pending results=%0d reads=%0d required 0 and 0",
                        cyc, sb.size(), addrq.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
      end
   end

   // One request from voice v; alt>=0 rewrites its instr during ISSUE.
   task automatic lookup(input int v, input logic [4:0] ins, input logic [7:0] off,
                         input logic e, input int alt);
      exp_t x;
      @(negedge clk); #1;
      bus.instr[5*v +: 5] = ins;
      bus.req[v] = 1'b1;
      x.voice = v; x.off = off; x.err = e; x.cyc = cyc + 3;
      sb.push_back(x);
      if (!e) addrq.push_back(ins);
      for (int n = 0; n < 10; n++) begin
         @(negedge clk); #1;
         if (n == 0 && alt >= 0) bus.instr[5*v +: 5] = 5'(alt);
         if (bus.ack[v] === 1'b1) break;
      end
      bus.req[v] = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk); #1;
      rst = 1'b1; quiet = 1'b1;
      @(negedge clk); #1;
      rst = 1'b0; quiet = 1'b0;
   endtask

   // Directed stimulus.
   initial begin : stimulus
      exp_t       x;
      int         base;
      logic [7:0] exp_all [8];
      exp_all = '{8'h10, 8'h13, 8'h16, 8'h19, 8'h1C, 8'h1F, 8'h22, 8'h25};
      for (int i = 0; i < 32; i++) rom[i] = (i < 29) ? 8'(8'h10 + i) : 8'hEE;
      rom[7] = 8'h5A;
      bus.req   = '0;
      bus.instr = '0;

      // Reset, then ten idle cycles with everything at zero.
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      repeat (10) @(negedge clk);
      #1 quiet = 1'b0;

      // Single lookup: voice 2, instrument 7.
      lookup(2, 5'd7, 8'h5A, 1'b0, -1);

      // All voices requesting from reset: 0..7 then 0, three cycles apart.
      pulse_reset();
      @(negedge clk); #1;
      for (int v = 0; v < 8; v++) bus.instr[5*v +: 5] = 5'(3 * v);
      base = cyc;
      bus.req = '1;
      for (int k = 0; k < 9; k++) begin
         x.voice = k % 8; x.off = exp_all[k % 8]; x.err = 1'b0; x.cyc = base + 3 * (k + 1);
         sb.push_back(x);
         addrq.push_back(5'(3 * (k % 8)));
      end
      while (cyc < base + 27) begin
         @(negedge clk); #1;
      end
      bus.req = '0;

      // Out-of-range instruments, then the last valid one.
      lookup(5, 5'd29, 8'h00, 1'b1, -1);
      lookup(5, 5'd31, 8'h00, 1'b1, -1);
      lookup(5, 5'd28, 8'h2C, 1'b0, -1);

      // Reset during CAPTURE for voice 3, then re-served after release.
      @(negedge clk); #1;
      bus.instr[15 +: 5] = 5'd10;
      bus.req[3] = 1'b1;
      addrq.push_back(5'd10);
      @(negedge clk); #1;
      @(negedge clk); #1;
      rst = 1'b1; quiet = 1'b1;
      @(negedge clk); #1;
      rst = 1'b0; quiet = 1'b0;
      x.voice = 3; x.off = 8'h1A; x.err = 1'b0; x.cyc = cyc + 3;
      sb.push_back(x);
      addrq.push_back(5'd10);
      for (int n = 0; n < 10; n++) begin
         @(negedge clk); #1;
         if (bus.ack[3] === 1'b1) break;
      end
      bus.req[3] = 1'b0;

      // Voice 1 changes instr 4 -> 9 during ISSUE; answer is ROM[4].
      lookup(1, 5'd4, 8'h14, 1'b0, 9);

      repeat (5) @(negedge clk);
      #1 done = 1'b1;
   end

endmodule
